mem_port_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the core's instruction-fetch path and its load/store unit. Arbitrates one access per cycle, returns read data one cycle after grant, and routes each response to its requester. Drives `fetch_stall` straight into the PC register's `stall` input. Sits between the fetch/decode front end and the unified on-chip memory.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port synchronous RAM between instruction fetch and the load/store unit.
// Latency : grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: the losing requester sees ready low and holds its request; fetch_stall mirrors that for the PC.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   if_req_* / if_rsp_* / if_flush instruction-fetch request and response path
//   ls_req_* / ls_rsp_*           load/store request and response path (stores get no response)
//   mem_*                         single-port RAM drive (word address, byte write enables)
//   fetch_stall                   if_req_valid & ~if_req_ready, fed to the PC register stall input
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation counter.
// Without it the LSU has strict priority and MAX_WAIT is ignored.

module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,

  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [3:0]        ls_req_be,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              fetch_stall
);

  // Owner of the read data that the RAM presents in the following cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  logic       grant_if;
  logic       grant_ls;
  logic       force_if;
  logic [1:0] rsp_owner;
  logic [1:0] rsp_owner_nxt;

  // ---------------------------------------------------------------------------
  // Fetch starvation guard
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;

  // Once fetch has been denied WAIT_LIMIT times in a row it takes the next
  // contended cycle; the fetch grant then clears the count.
  assign force_if = (starve_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && (starve_cnt != WAIT_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;

  // MAX_WAIT has no effect with strict LSU priority.
  logic [31:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT;
`endif

  // ---------------------------------------------------------------------------
  // Grant: combinational, one winner per cycle, nothing granted in reset.
  // ---------------------------------------------------------------------------
  assign grant_if = ~rst & if_req_valid & (~ls_req_valid | force_if);
  assign grant_ls = ~rst & ls_req_valid & ~grant_if;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign fetch_stall  = if_req_valid & ~if_req_ready;

  // ---------------------------------------------------------------------------
  // RAM drive: taken from the granted port, all zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = grant_if | grant_ls;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_if) begin
      mem_addr = if_req_addr[ADDR_W-1:2];
    end else if (grant_ls) begin
      mem_addr  = ls_req_addr[ADDR_W-1:2];
      mem_wdata = ls_req_wdata;
      if (ls_req_we) begin
        mem_we = ls_req_be;
      end
    end
  end

  // Byte offsets are ignored: the RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[1:0], ls_req_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Response owner: reloaded every cycle so a store or idle cycle leaves no
  // stale owner behind.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_owner_nxt = OWN_NONE;
    if (grant_if) begin
      rsp_owner_nxt = OWN_IF;
    end else if (grant_ls && !ls_req_we) begin
      rsp_owner_nxt = OWN_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_owner <= OWN_NONE;
    end else begin
      rsp_owner <= rsp_owner_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing. Gating with rst drops a response that was outstanding
  // when reset arrived. A flush only kills the fetch response due now; a new
  // fetch granted in the same cycle still gets its data next cycle.
  // ---------------------------------------------------------------------------
  assign if_rsp_valid = ~rst & (rsp_owner == OWN_IF) & ~if_flush;
  assign ls_rsp_valid = ~rst & (rsp_owner == OWN_LS);

  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_data  = ls_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [3:0]        ls_req_be;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              fetch_stall;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fetch_stall(fetch_stall)
  );

  // RAM model (write-first, one-cycle read latency) and the bench's own
  // expected memory contents.
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rdata_q;
  assign mem_rdata = rdata_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      ram[mem_addr[7:0]] <= merge(ram[mem_addr[7:0]], mem_wdata, mem_we);
      rdata_q            <= merge(ram[mem_addr[7:0]], mem_wdata, mem_we);
    end
  end

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_ls_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0;
    ls_req_wdata = '0; ls_req_be = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h20;
    ls_req_wdata = 32'hFFFF_FFFF; ls_req_be = 4'b1111;
    tick(); tick();
    @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {if_req_ready, ls_req_ready}); end
    checks++; if ({mem_en, mem_we} !== 5'b0) begin
      failures++; $display("FAIL reset_mem got=%b exp=00000", {mem_en, mem_we}); end
    checks++; if ({if_rsp_valid, ls_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {if_rsp_valid, ls_rsp_valid}); end
    checks++; if ((if_rsp_data | ls_rsp_data) !== 32'h0) begin
      failures++; $display("FAIL reset_rsp_data got=%h/%h exp=0", if_rsp_data, ls_rsp_data); end
    tick();
    idle();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid, mem_en} !== 3'b000) begin
      failures++; $display("FAIL reset_release got=%b exp=000", {if_rsp_valid, ls_rsp_valid, mem_en}); end
    tick();
  endtask

  task automatic test_fetch_only();
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready, fetch_stall} !== 3'b100) begin
      failures++; $display("FAIL fetch_grant got=%b exp=100", {if_req_ready, ls_req_ready, fetch_stall}); end
    checks++; if (mem_addr !== 30'd4 || mem_en !== 1'b1 || mem_we !== 4'b0) begin
      failures++; $display("FAIL fetch_mem got=%h/%b/%b exp=4/1/0000", mem_addr, mem_en, mem_we); end
    exp_if_q.push_back(ref_mem[4]);
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== (exp_if_q.size() != 0)) begin
      failures++; $display("FAIL fetch_rsp_valid got=%b exp=%b", if_rsp_valid, exp_if_q.size() != 0);
    end else if (if_rsp_valid && if_rsp_data !== exp_if_q[0]) begin
      failures++; $display("FAIL fetch_rsp_data got=%h exp=%h", if_rsp_data, exp_if_q[0]); end
    if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
    checks++; if (ls_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL fetch_ls_quiet got=%b exp=0", ls_rsp_valid); end
    tick();
  endtask

  task automatic test_contention();
    int  stalls;
    int  exp_stalls;
    bit  exp_if_g;
    stalls = 0;
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    ls_req_valid = 1'b1; ls_req_addr = 32'h40;
    for (int c = 0; c <= 16; c++) begin
      if (c == 16) idle();
      @(negedge clk);
      checks++; if (if_rsp_valid !== (exp_if_q.size() != 0)) begin
        failures++; $display("FAIL cont_if_rsp c=%0d got=%b exp=%b", c, if_rsp_valid, exp_if_q.size() != 0);
      end else if (if_rsp_valid && if_rsp_data !== exp_if_q[0]) begin
        failures++; $display("FAIL cont_if_data c=%0d got=%h exp=%h", c, if_rsp_data, exp_if_q[0]); end
      if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
      checks++; if (ls_rsp_valid !== (exp_ls_q.size() != 0)) begin
        failures++; $display("FAIL cont_ls_rsp c=%0d got=%b exp=%b", c, ls_rsp_valid, exp_ls_q.size() != 0);
      end else if (ls_rsp_valid && ls_rsp_data !== exp_ls_q[0]) begin
        failures++; $display("FAIL cont_ls_data c=%0d got=%h exp=%h", c, ls_rsp_data, exp_ls_q[0]); end
      if (exp_ls_q.size() != 0) void'(exp_ls_q.pop_front());
      if (c == 16) break;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if_g = ((c % (MAX_WAIT + 1)) == MAX_WAIT);
`else
      exp_if_g = 1'b0;
`endif
      checks++; if ({if_req_ready, ls_req_ready, fetch_stall} !== {exp_if_g, !exp_if_g, !exp_if_g}) begin
        failures++; $display("FAIL cont_grant c=%0d got=%b exp=%b", c,
                             {if_req_ready, ls_req_ready, fetch_stall}, {exp_if_g, !exp_if_g, !exp_if_g}); end
      if (fetch_stall) stalls++;
      if (exp_if_g) exp_if_q.push_back(ref_mem[4]);
      else          exp_ls_q.push_back(ref_mem[16]);
      tick();
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_stalls = 16 - 16 / (MAX_WAIT + 1);
`else
    exp_stalls = 16;
`endif
    checks++; if (stalls !== exp_stalls) begin
      failures++; $display("FAIL cont_stall_count got=%0d exp=%0d", stalls, exp_stalls); end
    tick();
  endtask

  task automatic test_store_load();
    idle();
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h20;
    ls_req_wdata = 32'hDEAD_BEEF; ls_req_be = 4'b0011;
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 30'd8
                  || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL store_drive got=%b/%b/%h/%h exp=1/0011/8/deadbeef",
                           ls_req_ready, mem_we, mem_addr, mem_wdata); end
    ref_mem[8] = merge(ref_mem[8], 32'hDEAD_BEEF, 4'b0011);
    tick();
    ls_req_we = 1'b0; ls_req_wdata = '0; ls_req_be = 4'b0000;
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL store_no_rsp got=%b exp=0", ls_rsp_valid); end
    checks++; if (ls_req_ready !== 1'b1 || mem_we !== 4'b0000) begin
      failures++; $display("FAIL load_drive got=%b/%b exp=1/0000", ls_req_ready, mem_we); end
    exp_ls_q.push_back(ref_mem[8]);
    tick();
    idle();
    @(negedge clk);
    checks++; if (ls_rsp_valid !== (exp_ls_q.size() != 0)) begin
      failures++; $display("FAIL load_rsp_valid got=%b exp=%b", ls_rsp_valid, exp_ls_q.size() != 0);
    end else if (ls_rsp_valid && ls_rsp_data !== exp_ls_q[0]) begin
      failures++; $display("FAIL load_rsp_data got=%h exp=%h", ls_rsp_data, exp_ls_q[0]); end
    if (exp_ls_q.size() != 0) void'(exp_ls_q.pop_front());
    tick();
  endtask

  task automatic test_flush();
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    @(negedge clk);
    exp_if_q.push_back(ref_mem[4]);
    tick();
    if_flush = 1'b1; if_req_addr = 32'h14;
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h0) begin
      failures++; $display("FAIL flush_drop got=%b/%h exp=0/0", if_rsp_valid, if_rsp_data); end
    if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
    checks++; if (if_req_ready !== 1'b1 || mem_addr !== 30'd5) begin
      failures++; $display("FAIL flush_new_grant got=%b/%h exp=1/5", if_req_ready, mem_addr); end
    exp_if_q.push_back(ref_mem[5]);
    tick();
    idle();
    @(negedge clk);
    checks++; if (if_rsp_valid !== (exp_if_q.size() != 0)) begin
      failures++; $display("FAIL flush_next_rsp got=%b exp=%b", if_rsp_valid, exp_if_q.size() != 0);
    end else if (if_rsp_valid && if_rsp_data !== exp_if_q[0]) begin
      failures++; $display("FAIL flush_next_data got=%h exp=%h", if_rsp_data, exp_if_q[0]); end
    if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
    tick();
  endtask

  task automatic test_back_to_back();
    bit          kind [0:3];  // 1 = load, 0 = fetch
    int unsigned word [0:3];
    kind = '{1'b1, 1'b0, 1'b1, 1'b0};
    word = '{16, 4, 17, 5};
    for (int i = 0; i <= 4; i++) begin
      idle();
      if (i < 4) begin
        if (kind[i]) begin ls_req_valid = 1'b1; ls_req_addr = 32'(word[i] * 4); end
        else         begin if_req_valid = 1'b1; if_req_addr = 32'(word[i] * 4); end
      end
      @(negedge clk);
      checks++; if (if_rsp_valid !== (exp_if_q.size() != 0) || ls_rsp_valid !== (exp_ls_q.size() != 0)) begin
        failures++; $display("FAIL b2b_valid i=%0d got=%b%b exp=%b%b", i, if_rsp_valid, ls_rsp_valid,
                             exp_if_q.size() != 0, exp_ls_q.size() != 0);
      end else if ((if_rsp_valid && if_rsp_data !== exp_if_q[0]) ||
                   (ls_rsp_valid && ls_rsp_data !== exp_ls_q[0])) begin
        failures++; $display("FAIL b2b_data i=%0d got=%h/%h", i, if_rsp_data, ls_rsp_data); end
      if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
      if (exp_ls_q.size() != 0) void'(exp_ls_q.pop_front());
      if (i < 4) begin
        if (kind[i]) exp_ls_q.push_back(ref_mem[word[i]]);
        else         exp_if_q.push_back(ref_mem[word[i]]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    ls_req_valid = 1'b1; ls_req_addr = 32'h40;
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_pre_grant got=%b exp=1", ls_req_ready); end
    exp_ls_q.push_back(ref_mem[16]);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b0 || ls_rsp_data !== 32'h0) begin
      failures++; $display("FAIL rmid_drop got=%b/%h exp=0/0", ls_rsp_valid, ls_rsp_data); end
    checks++; if ({if_req_ready, ls_req_ready, mem_en} !== 3'b000) begin
      failures++; $display("FAIL rmid_ready got=%b exp=000", {if_req_ready, ls_req_ready, mem_en}); end
    exp_ls_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL rmid_post_rsp got=%b exp=00", {if_rsp_valid, ls_rsp_valid}); end
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b01) begin
      failures++; $display("FAIL rmid_rearb got=%b exp=01", {if_req_ready, ls_req_ready}); end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++; if (dut.starve_cnt !== 4'd0) begin
      failures++; $display("FAIL rmid_counter got=%0d exp=0", dut.starve_cnt); end
`endif
    exp_ls_q.push_back(ref_mem[16]);
    tick();
    idle();
    @(negedge clk);
    checks++; if (ls_rsp_valid !== (exp_ls_q.size() != 0)) begin
      failures++; $display("FAIL rmid_resume got=%b exp=%b", ls_rsp_valid, exp_ls_q.size() != 0);
    end else if (ls_rsp_valid && ls_rsp_data !== exp_ls_q[0]) begin
      failures++; $display("FAIL rmid_resume_data got=%h exp=%h", ls_rsp_data, exp_ls_q[0]); end
    if (exp_ls_q.size() != 0) void'(exp_ls_q.pop_front());
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rdata_q = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    ram[4] = 32'h0000_0093; ref_mem[4] = 32'h0000_0093;
    ram[8] = 32'h1111_1111; ref_mem[8] = 32'h1111_1111;
    rst = 1'b1;
    idle();
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
